proc_control: RTL and testbench

//  Control unit of the simple multi-cycle processor; direct consumer of the 2-bit timestep counter (upcount2).
//  - Latches each instruction from DIN into an internal IR.
//  - Decodes IR together with the timestep CNT (T0..T3) into register-file, accumulator and ALU strobes.
//  - Drives the counter's synchronous clear (CNT_CLR) so every instruction restarts at T0.

---
 rtl/proc_control_pkg.sv | 28 ++
 rtl/proc_control_if.sv | 32 +++
 rtl/proc_control_reg_dec.sv | 16 +
 rtl/proc_control.sv | 133 +++++++++++++
 tb/tb_proc_control.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/proc_control_pkg.sv
// rtl/proc_control_pkg.sv - opcodes, IR field positions and timestep constants for proc_control
package proc_control_pkg;

    localparam int IR_W = 9;
    localparam int NREG = 8;

    // Instruction format III XXX YYY
    localparam int OP_MSB = 8;
    localparam int OP_LSB = 6;
    localparam int RX_MSB = 5;
    localparam int RX_LSB = 3;
    localparam int RY_MSB = 2;
    localparam int RY_LSB = 0;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_MVNZ = 3'b100
    } opcode_t;

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

endpackage

// File: rtl/proc_control_if.sv
// rtl/proc_control_if.sv - control-unit bus: instruction/timestep inputs and datapath strobes
interface proc_control_if #(
    parameter int IR_W = 9,
    parameter int NREG = 8
);
    logic            Run;
    logic [IR_W-1:0] DIN;
    logic [1:0]      CNT;
    logic            Gnz;
    logic            CNT_CLR;
    logic            IRin;
    logic [NREG-1:0] Rin;
    logic [NREG-1:0] Rout;
    logic            DINout;
    logic            Ain;
    logic            Gin;
    logic            Gout;
    logic            AddSub;
    logic            Done;
    logic            Busy;
    logic            Err;

    modport master (
        output Run, DIN, CNT, Gnz,
        input  CNT_CLR, IRin, Rin, Rout, DINout, Ain, Gin, Gout, AddSub, Done, Busy, Err
    );

    modport slave (
        input  Run, DIN, CNT, Gnz,
        output CNT_CLR, IRin, Rin, Rout, DINout, Ain, Gin, Gout, AddSub, Done, Busy, Err
    );
endinterface

// File: rtl/proc_control_reg_dec.sv
// rtl/proc_control_reg_dec.sv - 3-to-NREG one-hot register decoder with enable
module reg_dec #(
    parameter int NREG = 8
) (
    input  logic            en,
    input  logic [2:0]      sel,
    output logic [NREG-1:0] onehot
);

    // Select lines beyond the register count decode to all-zero
    always_comb begin
        onehot = '0;
        if (en && (int'(sel) < NREG)) onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/proc_control.sv
// rtl/proc_control.sv - multi-cycle processor control unit; CTRL_MVNZ_EN enables the mvnz opcode
module proc_control
    import proc_control_pkg::*;
#(
    parameter int IR_W = proc_control_pkg::IR_W,
    parameter int NREG = proc_control_pkg::NREG
) (
    input  logic          CLKb,
    input  logic          CLR,
    proc_control_if.slave bus
);

    logic [IR_W-1:0] ir;
    logic            busy;
    logic            err;
    logic [2:0]      op;
    logic            rin_en;
    logic            rout_en;
    logic            rout_sel_y;
    logic            undef_op;
    logic [2:0]      rout_idx;
    logic            is_arith;

    assign op         = ir[OP_MSB:OP_LSB];
    assign is_arith   = (op == OP_ADD) || (op == OP_SUB);
    assign rout_idx   = rout_sel_y ? ir[RY_MSB:RY_LSB] : ir[RX_MSB:RX_LSB];

`ifndef CTRL_MVNZ_EN
    logic unused_gnz;
    assign unused_gnz = bus.Gnz;
`endif

    // Strobe decode from IR and timestep; everything is held low while CLR is asserted
    always_comb begin
        rin_en      = 1'b0;
        rout_en     = 1'b0;
        rout_sel_y  = 1'b0;
        undef_op    = 1'b0;
        bus.DINout  = 1'b0;
        bus.Ain     = 1'b0;
        bus.Gin     = 1'b0;
        bus.Gout    = 1'b0;
        bus.AddSub  = 1'b0;
        bus.Done    = 1'b0;
        if (!CLR) begin
            case (bus.CNT)
                T1: begin
                    case (op)
                        OP_MV: begin
                            rout_en    = 1'b1;
                            rout_sel_y = 1'b1;
                            rin_en     = 1'b1;
                            bus.Done   = 1'b1;
                        end
                        OP_MVI: begin
                            bus.DINout = 1'b1;
                            rin_en     = 1'b1;
                            bus.Done   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            rout_en    = 1'b1;
                            bus.Ain    = 1'b1;
                        end
`ifdef CTRL_MVNZ_EN
                        OP_MVNZ: begin
                            rout_en    = bus.Gnz;
                            rout_sel_y = 1'b1;
                            rin_en     = bus.Gnz;
                            bus.Done   = 1'b1;
                        end
`endif
                        default: begin
                            bus.Done   = 1'b1;
                            undef_op   = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    if (is_arith) begin
                        rout_en    = 1'b1;
                        rout_sel_y = 1'b1;
                        bus.Gin    = 1'b1;
                        bus.AddSub = (op == OP_SUB);
                    end
                end
                T3: begin
                    // Single-step opcodes never reach T3; if one does, just finish it
                    bus.Done = 1'b1;
                    if (is_arith) begin
                        bus.Gout = 1'b1;
                        rin_en   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    reg_dec #(.NREG(NREG)) u_rin_dec (
        .en     (rin_en),
        .sel    (ir[RX_MSB:RX_LSB]),
        .onehot (bus.Rin)
    );

    reg_dec #(.NREG(NREG)) u_rout_dec (
        .en     (rout_en),
        .sel    (rout_idx),
        .onehot (bus.Rout)
    );

    assign bus.IRin    = !CLR && bus.Run && (bus.CNT == T0);
    assign bus.CNT_CLR = CLR || bus.Done || ((bus.CNT == T0) && !bus.Run);
    assign bus.Busy    = busy;
    assign bus.Err     = err;

    // IR capture, busy tracking and sticky error, on the same edge as the timestep counter
    always_ff @(negedge CLKb or posedge CLR) begin
        if (CLR) begin
            ir   <= '0;
            busy <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (bus.IRin) begin
                ir   <= bus.DIN;
                busy <= 1'b1;
            end else if (bus.Done) begin
                busy <= 1'b0;
            end
            if (undef_op) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_proc_control.sv
// tb/tb_proc_control.sv - scoreboard bench for proc_control with an upcount2 model
module tb_proc_control;

    logic CLKb = 1'b0;
    logic CLR  = 1'b1;

    proc_control_if #(.IR_W(9), .NREG(8)) bus ();

    proc_control dut (
        .CLKb (CLKb),
        .CLR  (CLR),
        .bus  (bus)
    );

`ifdef CTRL_MVNZ_EN
    localparam logic MVNZ = 1'b1;
`else
    localparam logic MVNZ = 1'b0;
`endif

    typedef struct {
        string       nm;
        logic [25:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 CLKb = ~CLKb;

    // Two-bit timestep counter, negedge, synchronous clear
    initial bus.CNT = 2'd0;
    always @(negedge CLKb) bus.CNT <= bus.CNT_CLR ? 2'd0 : bus.CNT + 2'd1;

    // Monitor: compare every presented cycle against the head of the scoreboard
    always @(posedge CLKb) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [25:0] act;
            e   = sb.pop_front();
            act = {bus.CNT_CLR, bus.IRin, bus.Rin, bus.Rout, bus.DINout, bus.Ain,
                   bus.Gin, bus.Gout, bus.AddSub, bus.Done, bus.Busy, bus.Err};
            total++;
            if (act !== e.v) begin
                bad++;
                $display("FAIL %s: got clr=%b irin=%b rin=%h rout=%h dagxad=%b busy=%b err=%b, want clr=%b irin=%b rin=%h rout=%h dagxad=%b busy=%b err=%b",
                         e.nm, act[25], act[24], act[23:16], act[15:8], act[7:2], act[1], act[0],
                         e.v[25], e.v[24], e.v[23:16], e.v[15:8], e.v[7:2], e.v[1], e.v[0]);
            end
        end
    end

    // dagxad = {DINout, Ain, Gin, Gout, AddSub, Done}
    task automatic expect_cyc(input string nm, input logic cc, input logic irin,
                              input logic [7:0] rin, input logic [7:0] rout,
                              input logic [5:0] dagxad, input logic busy, input logic err);
        exp_t e;
        e.nm = nm;
        e.v  = {cc, irin, rin, rout, dagxad, busy, err};
        sb.push_back(e);
    endtask

    task automatic tick(input logic run, input logic [8:0] din, input logic gnz);
        @(negedge CLKb);
        #1;
        bus.Run = run;
        bus.DIN = din;
        bus.Gnz = gnz;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.Run = 1'b0;
        bus.DIN = '0;
        bus.Gnz = 1'b0;
        expect_cyc("reset", 1, 0, 8'h00, 8'h00, 6'b000000, 0, 0);

        // mvi R3, back-to-back into sub R2,R5 with Run held
        tick(1, 9'b001_011_000, 0); CLR = 1'b0;
        expect_cyc("mvi_t0", 0, 1, 8'h00, 8'h00, 6'b000000, 0, 0);
        tick(1, 9'b000_000_000, 0);
        expect_cyc("mvi_t1", 1, 0, 8'h08, 8'h00, 6'b100001, 1, 0);
        tick(1, 9'b011_010_101, 0);
        expect_cyc("sub_t0", 0, 1, 8'h00, 8'h00, 6'b000000, 0, 0);
        tick(0, 9'b000_000_000, 0);
        expect_cyc("sub_t1", 0, 0, 8'h00, 8'h04, 6'b010000, 1, 0);
        tick(0, 9'b000_000_000, 0);
        expect_cyc("sub_t2", 0, 0, 8'h00, 8'h20, 6'b001010, 1, 0);
        tick(0, 9'b000_000_000, 0);
        expect_cyc("sub_t3", 1, 0, 8'h04, 8'h00, 6'b000101, 1, 0);

        // idle with Run low
        for (int i = 0; i < 3; i++) begin
            tick(0, 9'b010_111_111, 0);
            expect_cyc("idle", 1, 0, 8'h00, 8'h00, 6'b000000, 0, 0);
        end

        // undefined opcode, sticky error across a following mv R1,R6
        tick(1, 9'b111_000_000, 0);
        expect_cyc("bad_t0", 0, 1, 8'h00, 8'h00, 6'b000000, 0, 0);
        tick(0, 9'b000_000_000, 0);
        expect_cyc("bad_t1", 1, 0, 8'h00, 8'h00, 6'b000001, 1, 0);
        tick(0, 9'b000_000_000, 0);
        expect_cyc("err_set", 1, 0, 8'h00, 8'h00, 6'b000000, 0, 1);
        tick(1, 9'b000_001_110, 0);
        expect_cyc("mv_t0", 0, 1, 8'h00, 8'h00, 6'b000000, 0, 1);
        tick(0, 9'b000_000_000, 0);
        expect_cyc("mv_t1", 1, 0, 8'h02, 8'h40, 6'b000001, 1, 1);

        // add R0,R7 full run
        tick(1, 9'b010_000_111, 0);
        expect_cyc("add_t0", 0, 1, 8'h00, 8'h00, 6'b000000, 0, 1);
        tick(0, 9'b000_000_000, 0);
        expect_cyc("add_t1", 0, 0, 8'h00, 8'h01, 6'b010000, 1, 1);
        tick(0, 9'b000_000_000, 0);
        expect_cyc("add_t2", 0, 0, 8'h00, 8'h80, 6'b001000, 1, 1);
        tick(0, 9'b000_000_000, 0);
        expect_cyc("add_t3", 1, 0, 8'h01, 8'h00, 6'b000101, 1, 1);

        // second add aborted by CLR at T2, between clock edges
        tick(1, 9'b010_000_111, 0);
        expect_cyc("add2_t0", 0, 1, 8'h00, 8'h00, 6'b000000, 0, 1);
        tick(0, 9'b000_000_000, 0);
        expect_cyc("add2_t1", 0, 0, 8'h00, 8'h01, 6'b010000, 1, 1);
        tick(0, 9'b000_000_000, 0); CLR = 1'b1;
        expect_cyc("clr_mid_add", 1, 0, 8'h00, 8'h00, 6'b000000, 0, 0);
        tick(0, 9'b000_000_000, 0); CLR = 1'b0;
        expect_cyc("after_clr", 1, 0, 8'h00, 8'h00, 6'b000000, 0, 0);

        // opcode 100 with Gnz low, then high
        tick(1, 9'b100_001_010, 0);
        expect_cyc("mvnz0_t0", 0, 1, 8'h00, 8'h00, 6'b000000, 0, 0);
        tick(0, 9'b000_000_000, 0);
        expect_cyc("mvnz0_t1", 1, 0, 8'h00, 8'h00, 6'b000001, 1, 0);
        tick(1, 9'b100_001_010, 1);
        expect_cyc("mvnz1_t0", 0, 1, 8'h00, 8'h00, 6'b000000, 0, !MVNZ);
        tick(0, 9'b000_000_000, 1);
        expect_cyc("mvnz1_t1", 1, 0, MVNZ ? 8'h02 : 8'h00, MVNZ ? 8'h04 : 8'h00,
                   6'b000001, 1, !MVNZ);
        tick(0, 9'b000_000_000, 0);
        expect_cyc("final_idle", 1, 0, 8'h00, 8'h00, 6'b000000, 0, !MVNZ);

        @(posedge CLKb);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
